// File: rtl/uart_pkg.sv
// uart_pkg: shared FIFO defaults and read-mode constants
package uart_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int FWFT_REG   = 0;
  localparam int FWFT_FALL  = 1;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: single write port, asynchronous read port storage array
module fifo_ram
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // store the accepted write word; the array is never cleared
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign q = mem[ra];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: parameterized synchronous FIFO with registered flags and sticky error bits
module param_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FWFT_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_CNT   = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT   = AE_LEVEL[ADDR_W:0];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head, r_q;
  logic              wr_ok, rd_ok;
  logic [ADDR_W:0]   cnt_n;
  // a write into a full FIFO only succeeds when a read frees a slot in the same cycle
  always_comb begin
    rd_ok = rd && !empty;
    wr_ok = wr && (!full || rd);
    cnt_n = count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
  end
  fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(wr_ok),
    .wa(wr_ptr),
    .wd(w_data),
    .ra(rd_ptr),
    .q(head)
  );
  // pointers, occupancy and flags, all derived from the post-edge count
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      wr_ptr       <= wr_ok ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr       <= rd_ok ? rd_ptr + ADDR_W'(1) : rd_ptr;
      count        <= cnt_n;
      empty        <= cnt_n == '0;
      full         <= cnt_n == FULL_CNT;
      almost_empty <= cnt_n <= AE_CNT;
      almost_full  <= cnt_n >= AF_CNT;
    end
  // sticky error bits; clr_err wins over a same-cycle set
  always_ff @(posedge clk)
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= clr_err ? 1'b0 : overflow || (wr && full && !rd);
      underflow <= clr_err ? 1'b0 : underflow || (rd && empty);
    end
  // registered read data, loaded only when a read is accepted
  always_ff @(posedge clk)
    if (rst) r_q <= '0;
    else if (rd_ok) r_q <= head;
  assign r_data = (FWFT == FWFT_FALL) ? (empty ? '0 : head) : r_q;
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W (16).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-008 SHALL have port wr  input  1  write request.
REQ-009 SHALL have port w_data  input  DATA_W  write data.
REQ-010 SHALL have port rd  input  1  read request.
REQ-011 SHALL have port r_data  output  DATA_W  read data.
REQ-012 SHALL have port empty  output  1  no words stored.
REQ-013 SHALL have port full  output  1  DEPTH words stored.
REQ-014 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-015 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-016 SHALL have port count  output  ADDR_W+1  words stored, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  sticky, write attempted while full.
REQ-018 SHALL have port underflow  output  1  sticky, read attempted while empty.
REQ-019 SHALL have port clr_err  input  1  clears overflow and underflow.

Function
REQ-020 Write accepted when wr=1 and (full=0, or rd=1 and full=1); w_data stored at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-021 Read accepted when rd=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-022 count, empty, full, almost_empty and almost_full are registered and reflect accepted operations the cycle after the edge.
REQ-023 Simultaneous accepted read and write: count unchanged, including when full.
REQ-024 rd=1, wr=1 while empty: write accepted, read rejected, underflow sets.
REQ-025 wr=1, rd=0 while full: write dropped, contents unchanged, overflow sets.
REQ-026 rd=1 while empty: no pointer change, r_data holds, underflow sets.
REQ-027 FWFT=0: r_data loads mem[rd_ptr] at the accepting edge (1-cycle latency), otherwise holds.
REQ-028 FWFT=1: r_data continuously shows the head word whenever empty=0; rd pops it; value is don't-care when empty.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL not corrupt data or flags.
REQ-030 overflow/underflow stay set until clr_err=1; clr_err takes priority over a same-cycle set.

Reset
REQ-031 rst=1 at a clock edge: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, r_data=0.
REQ-032 rst takes priority over rd, wr and clr_err in the same cycle; storage array is not cleared.
REQ-033 Reset mid-operation discards all stored words; first read after reset returns the first word written after reset.

Structure
REQ-034 Shared package uart_pkg SHALL hold default DATA_W, ADDR_W and the FWFT mode constants.
REQ-035 Storage SHALL be a single sub-module fifo_ram (one write port, one asynchronous read port); pointer/flag control lives in param_fifo.

Verification
REQ-036 Reset, then write 1..16 (defaults) -> full=1 after 16th, count=16, almost_full=1 from count=14.
REQ-037 Full, write 17 with rd=0 -> overflow=1, data unchanged; clr_err -> overflow=0.
REQ-038 Read 16 words, FWFT=0 -> r_data 1..16 each one cycle after rd, empty=1 after last; extra rd -> underflow=1.
REQ-039 Full, rd=1 and wr=1 with w_data=0xAA -> count stays 16, 0xAA read out last.
REQ-040 FWFT=1, write 0x55 -> r_data=0x55 the cycle after empty deasserts, with no rd.
REQ-041 Write 20 / read 20 interleaved across wrap, then rst mid-stream -> empty=1, count=0, order preserved throughout.
